// File: rtl/operand_skew_loader_if.sv
// rtl/operand_skew_loader_if.sv - operand vector stream and SRAM write port bundle
//
// Purpose: groups the upstream vector handshake and the downstream SRAM
// write port of operand_skew_loader.
// Signals:
//   i_in_valid / i_in_data / o_in_ready : unskewed operand vector stream
//   o_wr_en / o_wr_addr / o_wr_data     : skewed-word SRAM write port
// Modports:
//   slave  : the loader (consumes vectors, drives the write port)
//   master : the environment (supplies vectors, observes the write port)
interface operand_skew_loader_if #(
  parameter int NUM_LANES            = 16,
  parameter int DATA_WIDTH           = 16,
  parameter int LOG2_SRAM_BANK_DEPTH = 9
) ();

  logic                            i_in_valid;
  logic [NUM_LANES*DATA_WIDTH-1:0] i_in_data;
  logic                            o_in_ready;
  logic                            o_wr_en;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] o_wr_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0] o_wr_data;

  modport slave (
    input  i_in_valid,
    input  i_in_data,
    output o_in_ready,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data
  );

  modport master (
    output i_in_valid,
    output i_in_data,
    input  o_in_ready,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data
  );

endinterface

// File: rtl/operand_skew_loader.sv
// rtl/operand_skew_loader.sv - diagonal operand skew formatter for systolic array SRAM
//
// Purpose: accepts K unskewed operand vectors and writes K+NUM_LANES-1
// diagonally skewed words to consecutive SRAM addresses starting at the
// latched base. Lane j of output word m carries v[m-j][j], zero outside
// the valid range.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_start       : start pulse (IDLE only), latches i_base_addr / i_num_vec
//   i_base_addr   : first SRAM write address
//   i_num_vec     : K, number of vectors (0 ignores the start)
//   bus (slave)   : vector stream in, SRAM write port out
//   o_busy        : job in progress (LOAD or FLUSH)
//   o_done        : pulse with the final write
//   o_end_addr    : address of the last word of the job
module operand_skew_loader #(
  parameter int NUM_LANES            = 16,
  parameter int DATA_WIDTH           = 16,
  parameter int LOG2_SRAM_BANK_DEPTH = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_base_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_num_vec,
  operand_skew_loader_if.slave            bus,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_end_addr
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int DW = DATA_WIDTH;
  localparam int WW = NUM_LANES * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Flush runs NUM_LANES-1 steps; the counter restarts at 0 on FLUSH entry.
  localparam logic [AW-1:0] FLUSH_LAST = AW'(NUM_LANES > 1 ? NUM_LANES - 2 : 0);
  localparam logic [AW-1:0] TAIL_LEN   = AW'(NUM_LANES - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;         // next SRAM address to write
  logic [AW-1:0] k_last_q, k_last_d;     // K-1
  logic [AW-1:0] cnt_q, cnt_d;           // vectors accepted (LOAD) / flush steps (FLUSH)
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [WW-1:0] wr_data_q, wr_data_d;
  logic          done_q, done_d;
  logic [AW-1:0] end_addr_q, end_addr_d;

  logic          start_ok;
  logic          step;
  logic [WW-1:0] in_word;
  logic [WW-1:0] skew_word;

  assign start_ok = (state_q == ST_IDLE) && i_start && (i_num_vec != '0);
  assign step     = ((state_q == ST_LOAD) && bus.i_in_valid) || (state_q == ST_FLUSH);

  // Outside LOAD the input is forced to zero so FLUSH drains zeros into the lines.
  assign in_word = (state_q == ST_LOAD) ? bus.i_in_data : '0;

  assign skew_word[DW-1:0] = in_word[DW-1:0];

  // Lane j delays its input by j steps; lines are cleared at job start so no
  // data from an earlier job leaks into the leading words.
  for (genvar j = 1; j < NUM_LANES; j++) begin : g_lane
    logic [DW-1:0] dly_q [0:j-1];

    always_ff @(posedge clk) begin
      if (rst || start_ok) begin
        for (int i = 0; i < j; i++) dly_q[i] <= '0;
      end else if (step) begin
        dly_q[0] <= in_word[j*DW +: DW];
        for (int i = 1; i < j; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign skew_word[j*DW +: DW] = dly_q[j-1];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    k_last_d   = k_last_q;
    cnt_d      = cnt_q;
    wr_en_d    = step;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    end_addr_d = end_addr_q;

    if (step) begin
      wr_addr_d = addr_q;
      wr_data_d = skew_word;
      addr_d    = addr_q + AW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_LOAD;
          addr_d     = i_base_addr;
          k_last_d   = i_num_vec - AW'(1);
          cnt_d      = '0;
          end_addr_d = i_base_addr + i_num_vec - AW'(1) + TAIL_LEN;
        end
      end
      ST_LOAD: begin
        if (bus.i_in_valid) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == k_last_q) begin
            if (NUM_LANES == 1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FLUSH;
              cnt_d   = '0;
            end
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      k_last_q   <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      end_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      k_last_q   <= k_last_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      end_addr_q <= end_addr_d;
    end
  end

  assign bus.o_in_ready = (state_q == ST_LOAD);
  assign bus.o_wr_en    = wr_en_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_q;
  assign o_end_addr     = end_addr_q;

endmodule

// File: tb/tb_operand_skew_loader.sv
// tb/tb_operand_skew_loader.sv - directed bench for operand_skew_loader
module tb_operand_skew_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Four-lane instance
  logic        start4;
  logic [8:0]  base4, num4;
  logic        busy4, done4;
  logic [8:0]  end4;
  operand_skew_loader_if #(.NUM_LANES(4), .DATA_WIDTH(16), .LOG2_SRAM_BANK_DEPTH(9)) bus4 ();
  operand_skew_loader #(.NUM_LANES(4), .DATA_WIDTH(16), .LOG2_SRAM_BANK_DEPTH(9)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_base_addr(base4), .i_num_vec(num4),
    .bus(bus4), .o_busy(busy4), .o_done(done4), .o_end_addr(end4)
  );

  // Single-lane instance
  logic        start1;
  logic [8:0]  base1, num1;
  logic        busy1, done1;
  logic [8:0]  end1;
  operand_skew_loader_if #(.NUM_LANES(1), .DATA_WIDTH(16), .LOG2_SRAM_BANK_DEPTH(9)) bus1 ();
  operand_skew_loader #(.NUM_LANES(1), .DATA_WIDTH(16), .LOG2_SRAM_BANK_DEPTH(9)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_base_addr(base1), .i_num_vec(num1),
    .bus(bus1), .o_busy(busy1), .o_done(done1), .o_end_addr(end1)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]  q_addr [$];
  logic [63:0] q_data [$];
  logic        q_done [$];

  always @(negedge clk) begin
    if (bus4.o_wr_en) begin
      q_addr.push_back(bus4.o_wr_addr);
      q_data.push_back(bus4.o_wr_data);
      q_done.push_back(done4);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] vec4(input int k);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(16 * k + j);
    return v;
  endfunction

  // Skew rule: lane j of word m = v[m-j][j] when 0 <= m-j < K, else 0.
  function automatic logic [63:0] exp4(input int m, input int k);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (m - j >= 0 && m - j < k) w[j*16 +: 16] = 16'(16 * (m - j) + j);
    return w;
  endfunction

  task automatic run4(input int base, input int k, input bit gaps, input bit poke_start);
    int n;
    q_addr.delete(); q_data.delete(); q_done.delete();
    start4 = 1'b1; base4 = 9'(base); num4 = 9'(k);
    cyc();
    start4 = 1'b0;
    chk("load_ready", 64'(bus4.o_in_ready), 64'd1);
    for (int i = 0; i < k; i++) begin
      bus4.i_in_valid = 1'b1;
      bus4.i_in_data  = vec4(i);
      cyc();
      if (gaps && i < k - 1) begin
        bus4.i_in_valid = 1'b0;
        bus4.i_in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        cyc();
        chk("gap_no_write", 64'(bus4.o_wr_en), 64'd0);
        cyc();
      end
    end
    bus4.i_in_valid = 1'b0;
    if (poke_start) begin
      start4 = 1'b1; base4 = 9'd100; num4 = 9'd3;
      cyc();
      start4 = 1'b0;
      chk("flush_ready_low", 64'(bus4.o_in_ready), 64'd0);
    end
    n = 0;
    while (!done4 && n < 40) begin
      cyc();
      n++;
    end
    chk("done_seen", 64'(done4), 64'd1);
    chk("done_with_write", 64'(bus4.o_wr_en), 64'd1);
    chk("busy_low_at_done", 64'(busy4), 64'd0);
    cyc();
    cyc();
  endtask

  task automatic verify4(input int base, input int k);
    int dones;
    chk("write_count", 64'(q_addr.size()), 64'(k + 3));
    if (q_addr.size() == k + 3) begin
      dones = 0;
      for (int m = 0; m < k + 3; m++) begin
        chk("word_addr", 64'(q_addr[m]), 64'((base + m) % 512));
        chk("word_data", q_data[m], exp4(m, k));
        dones += int'(q_done[m]);
      end
      chk("done_on_last", 64'(q_done[k + 2]), 64'd1);
      chk("done_count", 64'(dones), 64'd1);
    end
    chk("end_addr", 64'(end4), 64'((base + k + 2) % 512));
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; base4 = '0; num4 = '0;
    start1 = 1'b0; base1 = '0; num1 = '0;
    bus4.i_in_valid = 1'b0; bus4.i_in_data = '0;
    bus1.i_in_valid = 1'b0; bus1.i_in_data = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_ready", 64'(bus4.o_in_ready), 64'd0);
    chk("rst_wr_en", 64'(bus4.o_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus4.o_wr_addr), 64'd0);
    chk("rst_wr_data", bus4.o_wr_data, 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_done", 64'(done4), 64'd0);
    chk("rst_end_addr", 64'(end4), 64'd0);
    rst = 1'b0;
    cyc();

    // Basic skew, base 5, K 4
    run4(5, 4, 1'b0, 1'b0);
    verify4(5, 4);
    if (q_data.size() == 7) begin
      chk("basic_word0", q_data[0], 64'h0000_0000_0000_0000);
      chk("basic_word1", q_data[1], 64'h0000_0000_0001_0010);
      chk("basic_word3", q_data[3], 64'h0003_0012_0021_0030);
      chk("basic_word6", q_data[6], 64'h0033_0000_0000_0000);
      chk("basic_addr6", 64'(q_addr[6]), 64'd11);
    end
    chk("basic_end_addr", 64'(end4), 64'd11);

    // Input gaps 1,0,0,1,...
    run4(5, 4, 1'b1, 1'b0);
    verify4(5, 4);

    // Address wrap-around
    run4(510, 2, 1'b0, 1'b0);
    verify4(510, 2);
    if (q_addr.size() == 5) begin
      chk("wrap_addr2", 64'(q_addr[2]), 64'd0);
      chk("wrap_addr4", 64'(q_addr[4]), 64'd2);
    end
    chk("wrap_end_addr", 64'(end4), 64'd2);

    // Start during FLUSH is ignored
    run4(20, 4, 1'b0, 1'b1);
    verify4(20, 4);
    chk("poke_end_addr", 64'(end4), 64'd26);

    // Start with K=0 is ignored
    q_addr.delete(); q_data.delete(); q_done.delete();
    start4 = 1'b1; base4 = 9'd77; num4 = 9'd0;
    cyc();
    start4 = 1'b0;
    chk("k0_ready", 64'(bus4.o_in_ready), 64'd0);
    chk("k0_busy", 64'(busy4), 64'd0);
    repeat (5) cyc();
    chk("k0_writes", 64'(q_addr.size()), 64'd0);
    chk("k0_end_addr", 64'(end4), 64'd26);

    // Reset mid-LOAD after two accepted vectors
    q_addr.delete(); q_data.delete(); q_done.delete();
    start4 = 1'b1; base4 = 9'd40; num4 = 9'd4;
    cyc();
    start4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus4.i_in_valid = 1'b1;
      bus4.i_in_data  = vec4(i + 5);
      cyc();
    end
    bus4.i_in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("mid_rst_ready", 64'(bus4.o_in_ready), 64'd0);
    chk("mid_rst_wr_en", 64'(bus4.o_wr_en), 64'd0);
    chk("mid_rst_wr_addr", 64'(bus4.o_wr_addr), 64'd0);
    chk("mid_rst_wr_data", bus4.o_wr_data, 64'd0);
    chk("mid_rst_busy", 64'(busy4), 64'd0);
    chk("mid_rst_done", 64'(done4), 64'd0);
    chk("mid_rst_end_addr", 64'(end4), 64'd0);
    rst = 1'b0;
    repeat (6) cyc();
    chk("mid_rst_writes", 64'(q_addr.size()), 64'd2);
    chk("mid_rst_no_done", 64'(q_done.size() == 2 ? int'(q_done[0]) + int'(q_done[1]) : 99), 64'd0);
    run4(0, 4, 1'b0, 1'b0);
    verify4(0, 4);

    // Single lane: 7, 8, 9 at base 0, no flush
    start1 = 1'b1; base1 = 9'd0; num1 = 9'd3;
    cyc();
    start1 = 1'b0;
    chk("one_ready", 64'(bus1.o_in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      bus1.i_in_valid = 1'b1;
      bus1.i_in_data  = 16'(7 + i);
      cyc();
      chk("one_wr_en", 64'(bus1.o_wr_en), 64'd1);
      chk("one_wr_addr", 64'(bus1.o_wr_addr), 64'(i));
      chk("one_wr_data", 64'(bus1.o_wr_data), 64'(7 + i));
      chk("one_done", 64'(done1), 64'(i == 2));
    end
    bus1.i_in_valid = 1'b0;
    chk("one_busy_end", 64'(busy1), 64'd0);
    chk("one_ready_end", 64'(bus1.o_in_ready), 64'd0);
    chk("one_end_addr", 64'(end1), 64'd2);
    cyc();
    chk("one_no_flush", 64'(bus1.o_wr_en), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
